// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: the ownership state of the
// two-port arbitration FSM.
package typedefs_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    P0   = 2'd1,
    P1   = 2'd2
  } arb_owner_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter. The requester drives the
// access fields; the arbiter returns the grant and the read-return pair.
interface dmem_arbiter_if #(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 32
);

  logic              req;
  logic              we;
  logic [AWIDTH-1:0] addr;
  logic [DWIDTH-1:0] wdata;
  logic [3:0]        wmask;
  logic              gnt;
  logic              rvalid;
  logic [DWIDTH-1:0] rdata;

  modport master (
    output req, we, addr, wdata, wmask,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wmask,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter with a bounded hold on contention.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin contention; default is fixed priority to port 0.
module dmem_arbiter
  import typedefs_pkg::*;
#(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 10,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  dmem_arbiter_if.slave     p0,
  dmem_arbiter_if.slave     p1,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic [3:0]        mem_wmask,
  output logic              mem_wen,
  input  logic [DWIDTH-1:0] mem_rdata
);

  localparam int              CW       = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0]   HOLD_MAX = CW'(MAX_HOLD);

  arb_owner_t        owner, owner_nxt, win;
  logic [CW-1:0]     hold_cnt, hold_nxt;
  logic              rvalid0_q, rvalid1_q;
  logic [DWIDTH-1:0] rdata0_q, rdata1_q;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner    <= NONE;
      hold_cnt <= '0;
    end else begin
      owner    <= owner_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Next-state: pick this cycle's winner and advance ownership.
  // NOTE: every variable gets a default at the top so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    win       = NONE;
    owner_nxt = NONE;
    hold_nxt  = '0;
    if (!rst) begin
      unique case ({p1.req, p0.req})
        2'b01:   win = P0;
        2'b10:   win = P1;
        2'b11: begin
          if (owner != NONE && hold_cnt < HOLD_MAX) begin
            win = owner;
          end else begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            win = (owner == P0) ? P1 : P0;
`else
            win = P0;
`endif
          end
        end
        default: win = NONE;
      endcase

      if (win != NONE) begin
        owner_nxt = win;
        if (win == owner) begin
          hold_nxt = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + CW'(1);
        end else begin
          hold_nxt = CW'(1);
        end
      end
    end
  end

  // Outputs: grants, memory mux (port 0 when idle), gated read return.
  always_comb begin
    p0.gnt    = (win == P0);
    p1.gnt    = (win == P1);
    mem_addr  = p0.addr;
    mem_wdata = p0.wdata;
    mem_wmask = p0.wmask;
    if (win == P1) begin
      mem_addr  = p1.addr;
      mem_wdata = p1.wdata;
      mem_wmask = p1.wmask;
    end
    mem_wen   = (p0.gnt & p0.we) | (p1.gnt & p1.we);
    // Reset is synchronous, so a read granted just before rst would still
    // be sitting in the return register; mask it while rst is high.
    p0.rvalid = rvalid0_q & ~rst;
    p1.rvalid = rvalid1_q & ~rst;
    p0.rdata  = rst ? '0 : rdata0_q;
    p1.rdata  = rst ? '0 : rdata1_q;
  end

  // Read-return register: one-cycle rvalid pulse, data held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= p0.gnt & ~p0.we;
      rvalid1_q <= p1.gnt & ~p1.we;
      if (p0.gnt && !p0.we) rdata0_q <= mem_rdata;
      if (p1.gnt && !p1.we) rdata1_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic,
// compared every cycle against a behavioural model of the arbitration rules.
module tb_dmem_arbiter;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int MH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) p0_if ();
  dmem_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) p1_if ();

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wmask;
  logic          mem_wen;
  logic [DW-1:0] mem_rdata;

  dmem_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst       (rst),
    .p0        (p0_if),
    .p1        (p1_if),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_wen   (mem_wen),
    .mem_rdata (mem_rdata)
  );

  // Read-only memory image; word 4 (byte 0x10) holds 0xDEADBEEF.
  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    logic [AW-3:0] w;
    w = a[AW-1:2];
    if (w == 8'h04) return 32'hDEADBEEF;
    return 32'hA5C3_0000 ^ (32'(w) * 32'h9E3779B1);
  endfunction

  assign mem_rdata = mem_word(mem_addr);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: owner -1/0/1 and length of its current streak.
  int            m_owner  = -1;
  int            m_streak = 0;
  logic          m_rv [2] = '{1'b0, 1'b0};
  logic [31:0]   m_rd [2] = '{32'd0, 32'd0};
  logic          m_gnt [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin : model
    logic          rq [2];
    logic          w  [2];
    logic [AW-1:0] ad [2];
    logic [31:0]   wd [2];
    logic [3:0]    wm [2];
    int            g;
    int            s;
    rq[0] = p0_if.req;  w[0] = p0_if.we;  ad[0] = p0_if.addr;  wd[0] = p0_if.wdata;  wm[0] = p0_if.wmask;
    rq[1] = p1_if.req;  w[1] = p1_if.we;  ad[1] = p1_if.addr;  wd[1] = p1_if.wdata;  wm[1] = p1_if.wmask;

    g = -1;
    if (!rst) begin
      if (rq[0] && rq[1]) begin
        if (m_owner >= 0 && m_streak < MH) g = m_owner;
        else begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
          g = (m_owner == 0) ? 1 : 0;
`else
          g = 0;
`endif
        end
      end else if (rq[0]) g = 0;
      else if (rq[1]) g = 1;
    end
    s = (g == 1) ? 1 : 0;

    check("gnt0",      p0_if.gnt, g == 0);
    check("gnt1",      p1_if.gnt, g == 1);
    check("mem_wen",   mem_wen,   g >= 0 && w[s]);
    check("mem_addr",  mem_addr,  ad[s]);
    check("mem_wdata", mem_wdata, wd[s]);
    check("mem_wmask", mem_wmask, wm[s]);
    check("rvalid0",   p0_if.rvalid, rst ? 1'b0 : m_rv[0]);
    check("rvalid1",   p1_if.rvalid, rst ? 1'b0 : m_rv[1]);
    check("rdata0",    p0_if.rdata,  rst ? 32'd0 : m_rd[0]);
    check("rdata1",    p1_if.rdata,  rst ? 32'd0 : m_rd[1]);

    m_gnt[0] = (g == 0);
    m_gnt[1] = (g == 1);
    if (rst) begin
      m_owner  = -1;
      m_streak = 0;
      for (int p = 0; p < 2; p++) begin
        m_rv[p] = 1'b0;
        m_rd[p] = 32'd0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        m_rv[p] = (g == p) && !w[p];
        if (m_rv[p]) m_rd[p] = mem_word(ad[p]);
      end
      if (g < 0) begin
        m_owner  = -1;
        m_streak = 0;
      end else if (g == m_owner) begin
        if (m_streak < MH) m_streak++;
      end else begin
        m_owner  = g;
        m_streak = 1;
      end
    end
  end

  task automatic set_port(input int p, input logic rq, input logic we,
                          input logic [AW-1:0] ad, input logic [31:0] wd, input logic [3:0] wm);
    if (p == 0) begin
      p0_if.req = rq; p0_if.we = we; p0_if.addr = ad; p0_if.wdata = wd; p0_if.wmask = wm;
    end else begin
      p1_if.req = rq; p1_if.we = we; p1_if.addr = ad; p1_if.wdata = wd; p1_if.wmask = wm;
    end
  endtask

  task automatic idle_all();
    set_port(0, 1'b0, 1'b0, '0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_port(input int p);
    logic cur_req;
    cur_req = (p == 0) ? p0_if.req : p1_if.req;
    if (cur_req && !m_gnt[p]) return;
    set_port(p, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
             ($urandom_range(0, 3) == 0) ? AW'(10'h010) : AW'($urandom),
             $urandom, 4'($urandom));
  endtask

  logic [9:0] pat10;
  logic [3:0] pat4;

  initial begin
    rst = 1'b1;
    idle_all();
    repeat (2) next_cycle();

    // No grant while in reset, even with both ports requesting writes.
    set_port(0, 1'b1, 1'b1, 10'h010, 32'h1111_1111, 4'hF);
    set_port(1, 1'b1, 1'b1, 10'h020, 32'h2222_2222, 4'hF);
    @(negedge clk);
    check("rst_gnt0", p0_if.gnt, 1'b0);
    check("rst_gnt1", p1_if.gnt, 1'b0);
    check("rst_wen",  mem_wen,   1'b0);
    next_cycle();
    rst = 1'b0;
    idle_all();
    next_cycle();

    // Single-port read.
    set_port(0, 1'b1, 1'b0, 10'h010, 32'h0, 4'h0);
    @(negedge clk);
    check("rd_gnt0", p0_if.gnt, 1'b1);
    check("rd_gnt1", p1_if.gnt, 1'b0);
    next_cycle();
    idle_all();
    @(negedge clk);
    check("rd_rvalid0", p0_if.rvalid, 1'b1);
    check("rd_rdata0",  p0_if.rdata,  32'hDEADBEEF);
    check("rd_rvalid1", p1_if.rvalid, 1'b0);

    // Port 1 write.
    next_cycle();
    set_port(1, 1'b1, 1'b1, 10'h020, 32'h12345678, 4'b0011);
    @(negedge clk);
    check("wr_wen",   mem_wen,   1'b1);
    check("wr_addr",  mem_addr,  10'h020);
    check("wr_wmask", mem_wmask, 4'b0011);
    check("wr_wdata", mem_wdata, 32'h12345678);
    next_cycle();
    idle_all();
    @(negedge clk);
    check("wr_no_rvalid1", p1_if.rvalid, 1'b0);
    check("wr_wen_off",    mem_wen,      1'b0);

    // Contention from idle for 10 cycles.
    next_cycle();
    set_port(0, 1'b1, 1'b0, 10'h010, 32'h0, 4'h0);
    set_port(1, 1'b1, 1'b0, 10'h024, 32'h0, 4'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      pat10[i] = p1_if.gnt;
      next_cycle();
    end
    idle_all();
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    check("hold_pattern", pat10, 10'b00_1111_0000);
`else
    check("fixed_pattern", pat10, 10'b00_0000_0000);
`endif

    // Release: P0 holds two grants, drops; P1 takes over with a streak of 1.
    next_cycle();
    set_port(0, 1'b1, 1'b0, 10'h030, 32'h0, 4'h0);
    repeat (2) next_cycle();
    set_port(0, 1'b0, 1'b0, 10'h030, 32'h0, 4'h0);
    set_port(1, 1'b1, 1'b0, 10'h034, 32'h0, 4'h0);
    @(negedge clk);
    check("release_gnt1", p1_if.gnt, 1'b1);
    next_cycle();
    set_port(0, 1'b1, 1'b0, 10'h030, 32'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pat4[i] = p1_if.gnt;
      next_cycle();
    end
    idle_all();
    check("release_hold", pat4, 4'b0111);

    // Reset arriving right after a granted read.
    next_cycle();
    set_port(0, 1'b1, 1'b0, 10'h010, 32'h0, 4'h0);
    @(negedge clk);
    check("rr_gnt0", p0_if.gnt, 1'b1);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("rr_rvalid0", p0_if.rvalid, 1'b0);
    check("rr_rdata0",  p0_if.rdata,  32'd0);
    check("rr_gnt0_rst", p0_if.gnt,   1'b0);
    next_cycle();
    rst = 1'b0;
    idle_all();
    @(negedge clk);
    check("rr_rvalid0_after", p0_if.rvalid, 1'b0);
    next_cycle();
    set_port(0, 1'b1, 1'b0, 10'h010, 32'h0, 4'h0);
    next_cycle();
    idle_all();
    @(negedge clk);
    check("rr_reread_valid", p0_if.rvalid, 1'b1);
    check("rr_reread_data",  p0_if.rdata,  32'hDEADBEEF);

    // Random traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      rst = ($urandom_range(0, 99) == 0);
      rand_port(0);
      rand_port(1);
    end

    next_cycle();
    rst = 1'b0;
    idle_all();
    repeat (3) next_cycle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
